// File: rtl/memory_stm.sv
// Load/store engine: turns one load_data/store_data command into a single
// Wishbone classic cycle, stalls the core until it ends, returns extended load data.
module memory_stm #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_data,
    input  logic        store_data,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_value,
    output logic [31:0] load_value,
    output logic        stop_cycle,
    output logic        misaligned,
    output logic        bus_fault,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    state_t        state;
    logic [TW-1:0] count;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          req;
    logic          legal;
    logic [3:0]    sel_n;
    logic [31:0]   dat_n;
    logic [31:0]   shifted;
    logic [31:0]   ext;

    // A store wins over a simultaneous load, so legality is judged as a store.
    assign req = load_data | store_data;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~address[0];
            3'b010:  legal = (address[1:0] == 2'b00);
            3'b100:  legal = ~store_data;
            3'b101:  legal = ~store_data & ~address[0];
            default: legal = 1'b0;
        endcase
    end

    // Loads read the whole word and pick the lane afterwards; stores drive only their lanes.
    always_comb begin
        sel_n = 4'b1111;
        dat_n = 32'h0;
        if (store_data) begin
            case (funct3[1:0])
                2'b00: begin
                    sel_n = 4'b0001 << address[1:0];
                    dat_n = {4{store_value[7:0]}};
                end
                2'b01: begin
                    sel_n = 4'b0011 << address[1:0];
                    dat_n = {2{store_value[15:0]}};
                end
                default: begin
                    sel_n = 4'b1111;
                    dat_n = store_value;
                end
            endcase
        end
    end

    always_comb begin
        shifted = wb_dat_i >> {off_q, 3'b000};
        ext     = shifted;
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // The request cycle itself must stall, hence the combinational IDLE term.
    assign stop_cycle = ~rst & (((state == IDLE) & req & legal) | (state == BUS));
    assign misaligned = ~rst & (state == IDLE) & req & ~legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            load_value <= 32'h0;
            bus_fault  <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= 32'h0;
            wb_sel     <= 4'b0000;
            wb_dat_o   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    bus_fault <= 1'b0;
                    count     <= '0;
                    if (req && legal) begin
                        f3_q     <= funct3;
                        off_q    <= address[1:0];
                        wb_we    <= store_data;
                        wb_adr   <= {address[31:2], 2'b00};
                        wb_sel   <= sel_n;
                        wb_dat_o <= dat_n;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    count <= count + 1'b1;
                    // err takes precedence over a simultaneous ack.
                    if (wb_err || (!wb_ack && count == TMO)) begin
                        load_value <= 32'h0;
                        bus_fault  <= 1'b1;
                        wb_cyc     <= 1'b0;
                        wb_stb     <= 1'b0;
                        state      <= DONE;
                    end else if (wb_ack) begin
                        load_value <= wb_we ? 32'h0 : ext;
                        wb_cyc     <= 1'b0;
                        wb_stb     <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Unconditional return keeps a still-held command from restarting.
                    bus_fault <= 1'b0;
                    count     <= '0;
                    wb_we     <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/memory_stm.md
Name: memory_stm

Overview:
- Load/store execution engine for the core; responder to the control unit's `load_data` / `store_data` commands.
- Turns one command into a single Wishbone classic master cycle.
- Holds `stop_cycle` high until the access completes. The control unit uses `stop_cycle` to gate the register-file write for loads and the core uses it to stall.
- Returns aligned, sign- or zero-extended load data.

Parameters:
- TIMEOUT, 255: bus cycles allowed in BUS before the access is aborted as a fault.
- TW, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clk  input  1  core clock
- rst  input  1  reset, synchronous, active-high
- load_data  input  1  load command from control unit, held for the whole instruction
- store_data  input  1  store command from control unit, held for the whole instruction
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  input  32  effective byte address (rs1 + imm)
- store_value  input  32  rs2 value
- load_value  output  32  extended load result, valid in DONE
- stop_cycle  output  1  core stall request
- misaligned  output  1  one-cycle pulse: alignment violation or illegal funct3
- bus_fault  output  1  one-cycle pulse: wb_err or timeout
- wb_cyc, wb_stb  output  1  Wishbone cycle/strobe
- wb_we  output  1  write enable
- wb_adr  output  32  word address, {address[31:2],2'b00}
- wb_sel  output  4  byte lanes
- wb_dat_o  output  32  write data
- wb_dat_i  input  32  read data
- wb_ack, wb_err  input  1  slave termination

Behaviour:
- States: IDLE, BUS, DONE.
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- Command request: req = load_data | store_data. If both are asserted (illegal), the store wins.

IDLE:
- stop_cycle = req & legal, combinational, so the request cycle itself stalls.
- Legal access: latch address, we, funct3, lane-shifted data and sel; next state BUS.
- Illegal access (W with address[1:0]!=0; H/HU with address[0]=1; funct3 in {011,110,111}; store funct3 >010):
  - no bus cycle;
  - misaligned=1 for that cycle;
  - stop_cycle=0;
  - stay IDLE.

BUS:
- wb_cyc = wb_stb = 1, registered; wb_adr/we/sel/dat_o stable throughout; stop_cycle=1.
- Counter increments each cycle.
- wb_ack: capture extended data into load_value (stores leave it 0); next state DONE.
- wb_err, or counter == TIMEOUT without ack: load_value=0, bus_fault pulse in DONE, next state DONE. Ack and err in the same cycle is treated as err.

DONE:
- cyc/stb=0, stop_cycle=0, load_value valid; counter cleared.
- Next state unconditionally IDLE. This stops the still-high `load_data` from the finishing instruction from restarting the access.
- A new command is sampled in IDLE on the following cycle.

Lane rules, with off = address[1:0]:
- sel: B = 4'b0001<<off; H = 4'b0011<<off; W = 4'b1111.
- dat_o: B = {4{store_value[7:0]}}; H = {2{store_value[15:0]}}; W = store_value.
- Load: shifted = wb_dat_i >> (8*off), then:
  - B: sign-extend bit 7;
  - BU: zero-extend from 8 bits;
  - H: sign-extend bit 15;
  - HU: zero-extend from 16 bits;
  - W: unchanged.

Latency:
- Zero-wait slave (ack in the first stb cycle): 2 stall cycles (IDLE request cycle plus BUS); data in cycle 3.
- Each wait state adds 1 cycle.

Reset mid-access: cyc/stb deassert on the next edge with all outputs 0 and state IDLE. The slave must tolerate an abandoned cycle.

Test Plan:
- LW addr 0x100, slave returns 0xDEADBEEF with ack on first stb cycle -> stop_cycle high 2 cycles, wb_sel=1111, load_value=0xDEADBEEF in DONE, cyc never reasserts while load_data stays high in DONE.
- LB addr 0x103, wb_dat_i=0x80112233, 2 wait states -> wb_sel=1111 read, load_value=0xFFFFFF80, 4 stall cycles; same access as LBU -> 0x00000080.
- SH addr 0x202, store_value=0x0000ABCD -> wb_we=1, wb_adr=0x200, wb_sel=1100, wb_dat_o=0xABCDABCD, load_value=0.
- LW addr 0x101 -> misaligned pulses 1 cycle, stop_cycle=0, wb_cyc never asserted; funct3=011 gives the same response.
- Load with slave never acking, TIMEOUT=4 -> cyc held 5 cycles, bus_fault pulse, load_value=0, stop_cycle drops in DONE; wb_err on cycle 2 of another load gives the same fault response.
- rst asserted in BUS cycle 2 of a slow store -> next edge cyc/stb/we=0, stop_cycle=0, state IDLE; a following LW completes normally.
